pipeline_hazard_ctrl: RTL

// Consumer of the hazard unit's hazType code. Turns it into per-stage write-enable,

---
 rtl/pipeline_hazard_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: maps hazType to per-stage enable/flush/bubble controls,
// runs the cache-stall wait with timeout, and keeps saturating hazard counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W    = 16,
   parameter int WAIT_W   = 8,
   parameter int MAX_WAIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       hazType,
   input  logic             cache_ready,
   input  logic             clr_cnt,
   output logic             pc_wen,
   output logic             IF_ID_wen,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic             EX_MEM_wen,
   output logic             MEM_WB_wen,
   output logic             cache_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] cache_cnt,
   output logic             timeout_err
);
   typedef enum logic {RUN, CACHE_WAIT} state_e;
   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d, cache_q, cache_d;
   logic              timeout_q, timeout_d, set_to;
   logic              run, normal, stall, flush, enter;

   // Controls are forced low while rst is high, even before the state settles.
   assign run          = !rst && state_q == RUN;
   assign normal       = run && hazType == 2'd0;
   assign stall        = run && hazType == 2'd1;
   assign flush        = run && hazType == 2'd2;
   assign enter        = run && hazType == 2'd3;
   assign pc_wen       = normal || flush;
   assign IF_ID_wen    = normal || flush;
   assign EX_MEM_wen   = normal || stall || flush;
   assign MEM_WB_wen   = normal || stall || flush;
   assign IF_ID_flush  = flush;
   assign ID_EX_bubble = stall;
   assign cache_hold   = enter || (!rst && state_q == CACHE_WAIT);
   assign stall_cnt    = stall_q;
   assign flush_cnt    = flush_q;
   assign cache_cnt    = cache_q;
   assign timeout_err  = timeout_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      set_to  = 1'b0;
      if (state_q == RUN) begin
         if (hazType == 2'd3) begin
            state_d = CACHE_WAIT;
            wait_d  = '0;
         end
      end else if (cache_ready) begin
         state_d = RUN;
      end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
         state_d = RUN;
         set_to  = 1'b1;
      end else begin
         wait_d = wait_q + 1'b1;
      end
      stall_d   = clr_cnt ? '0 : stall_q + CNT_W'(stall && !(&stall_q));
      flush_d   = clr_cnt ? '0 : flush_q + CNT_W'(flush && !(&flush_q));
      cache_d   = clr_cnt ? '0 : cache_q + CNT_W'(enter && !(&cache_q));
      timeout_d = clr_cnt ? 1'b0 : timeout_q || set_to;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         stall_q   <= '0;
         flush_q   <= '0;
         cache_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
         cache_q   <= cache_d;
         timeout_q <= timeout_d;
      end
   end
endmodule
